// File: rtl/riscv_lsu_ctrl.sv
// Load/store sequencer between the core and a word-addressed data memory with a registered read port.
// Handles one byte-addressed RV32I load/store at a time: check, access, extract/extend, respond.
module riscv_lsu_ctrl #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              dm_wr,
  output logic [3:0]        dm_be,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata
);

  localparam int unsigned BYTE_ADDR_W = ADDR_W + 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_we;
  logic [2:0]          r_funct3;
  logic [1:0]          r_off;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic [31:0]         r_resp_rdata;
  logic                r_resp_err;
  logic                r_dm_wr;
  logic [3:0]          r_dm_be;
  logic [ADDR_W-1:0]   r_dm_addr;
  logic [31:0]         r_dm_wdata;

  logic                w_accept;
  logic                w_funct3_bad;
  logic                w_misaligned;
  logic                w_out_of_range;
  logic                w_err;
  logic [3:0]          w_be;
  logic [31:0]         w_wdata;
  logic [31:0]         w_shifted;
  logic [31:0]         w_ext;

  assign w_accept = req_valid & r_req_ready;

  // Request legality: encoding, natural alignment, and address inside the memory's byte space.
  always_comb begin
    w_funct3_bad   = 1'b0;
    w_misaligned   = 1'b0;
    w_out_of_range = 1'b0;
    unique case (req_funct3)
      3'b011, 3'b110, 3'b111: w_funct3_bad = 1'b1;
      3'b100, 3'b101:         w_funct3_bad = req_we;
      default:                w_funct3_bad = 1'b0;
    endcase
    if (req_funct3[1:0] == 2'b01) w_misaligned = req_addr[0];
    if (req_funct3[1:0] == 2'b10) w_misaligned = (req_addr[1:0] != 2'b00);
    w_out_of_range = ((req_addr >> BYTE_ADDR_W) != 32'd0);
    w_err = w_funct3_bad | w_misaligned | w_out_of_range;
  end

  // Byte lanes and lane-replicated store data.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = 32'd0;
    unique case (req_funct3[1:0])
      2'b00: begin
        w_be    = 4'(4'b0001 << req_addr[1:0]);
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'(4'b0011 << req_addr[1:0]);
        w_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = req_wdata;
      end
    endcase
    if (!req_we) w_wdata = 32'd0;
  end

  // Align the addressed lane to bit 0 and extend by access type.
  always_comb begin
    w_shifted = dm_rdata >> {r_off, 3'b000};
    w_ext     = 32'd0;
    unique case (r_funct3)
      3'b000:  w_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b010:  w_ext = w_shifted;
      3'b100:  w_ext = {24'd0, w_shifted[7:0]};
      3'b101:  w_ext = {16'd0, w_shifted[15:0]};
      default: w_ext = 32'd0;
    endcase
  end

  // Sequencer: IDLE -> ACCESS -> CAPTURE -> RESP, or IDLE -> RESP on a rejected request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_funct3     <= 3'd0;
      r_off        <= 2'd0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
      r_dm_wr      <= 1'b0;
      r_dm_be      <= 4'd0;
      r_dm_addr    <= '0;
      r_dm_wdata   <= 32'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we        <= req_we;
            r_funct3    <= req_funct3;
            r_off       <= req_addr[1:0];
            r_req_ready <= 1'b0;
            if (w_err) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'd0;
            end else begin
              r_state    <= S_ACCESS;
              r_dm_wr    <= req_we;
              r_dm_be    <= w_be;
              r_dm_addr  <= req_addr[BYTE_ADDR_W-1:2];
              r_dm_wdata <= w_wdata;
            end
          end
        end
        S_ACCESS: begin
          r_state    <= S_CAPTURE;
          r_dm_wr    <= 1'b0;
          r_dm_be    <= 4'd0;
          r_dm_wdata <= 32'd0;
        end
        S_CAPTURE: begin
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= r_we ? 32'd0 : w_ext;
        end
        S_RESP: begin
          if (resp_ready) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign dm_wr      = r_dm_wr;
  assign dm_be      = r_dm_be;
  assign dm_addr    = r_dm_addr;
  assign dm_wdata   = r_dm_wdata;

endmodule

// File: tb/tb_riscv_lsu_ctrl.sv
// Bench for riscv_lsu_ctrl: directed vector table, corner sequences and random traffic
// checked against a byte-level reference model with its own shadow memory.
module tb_riscv_lsu_ctrl;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned NWORDS = 1024;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr, req_wdata;
  logic              resp_valid, resp_ready, resp_err;
  logic [31:0]       resp_rdata;
  logic              dm_wr;
  logic [3:0]        dm_be;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata, dm_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem     [NWORDS];
  logic [31:0] ref_mem [NWORDS];

  riscv_lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dm_wr(dm_wr), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int j = 0; j < 4; j++)
      if (be[j]) r[8*j +: 8] = wd[8*j +: 8];
    return r;
  endfunction

  // Data memory: registered read, old data returned on a same-cycle write.
  always @(posedge clk) begin
    dm_rdata <= mem[dm_addr];
    if (dm_wr) mem[dm_addr] <= merge(mem[dm_addr], dm_wdata, dm_be);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: what the request must do, derived from byte-level access rules.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic err, output logic [31:0] rd,
                       output logic [3:0] be, output logic [31:0] dwd, output int idx);
    int size, off;
    logic [31:0] v;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off  = int'(a % 4);
    idx  = int'((a / 4) % NWORDS);
    err  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 >= 3'd4) ||
           (size == 2 && (off % 2) != 0) || (size == 4 && off != 0) ||
           (a >= 32'(4 * NWORDS));
    be = 4'd0;
    dwd = 32'd0;
    rd = 32'd0;
    for (int i = 0; i < size; i++) be = be | 4'(1 << (off + i));
    if (we)
      for (int j = 0; j < 4; j++)
        dwd = dwd | (((wd >> (8 * (j % size))) & 32'hFF) << (8 * j));
    if (!err && !we) begin
      v = 32'd0;
      for (int i = 0; i < size; i++)
        v = v | (((ref_mem[idx] >> (8 * (off + i))) & 32'hFF) << (8 * i));
      if (size < 4 && f3 < 3'd4 && ((v >> (8 * size - 1)) & 32'd1) == 32'd1)
        v = v | (32'hFFFF_FFFF << (8 * size));
      rd = v;
    end
    if (!err && we) ref_mem[idx] = merge(ref_mem[idx], dwd, be);
  endtask

  // One full transaction: issue, check memory-side signals, wait for response, hold, handshake.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int hold, input logic use_tbl,
                        input logic t_err, input logic [31:0] t_rd);
    logic m_err, e_err;
    logic [31:0] m_rd, m_dwd, e_rd, held;
    logic [3:0] m_be;
    int idx, lat, wr_cnt;
    bit got;
    model(we, f3, a, wd, m_err, m_rd, m_be, m_dwd, idx);
    e_err = use_tbl ? t_err : m_err;
    e_rd  = use_tbl ? t_rd  : m_rd;
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    got = 0; lat = 0; wr_cnt = 0;
    for (int k = 1; k <= 10 && !got; k++) begin
      @(negedge clk);
      if (dm_wr) wr_cnt++;
      if (k == 1 && !e_err) begin
        check("dm_addr", 32'(dm_addr), 32'(idx));
        check("dm_be", 32'(dm_be), 32'(m_be));
        check("dm_wdata", dm_wdata, m_dwd);
        check("dm_wr", 32'(dm_wr), 32'(we));
      end
      if (resp_valid) begin
        got = 1;
        lat = k;
      end
    end
    if (!got) begin
      check("resp_timeout", 32'd0, 32'd1);
    end else begin
      check("latency", 32'(lat), e_err ? 32'd1 : 32'd3);
      check("resp_err", 32'(resp_err), 32'(e_err));
      check("resp_rdata", resp_rdata, e_rd);
      held = resp_rdata;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("hold_valid", 32'(resp_valid), 32'd1);
        check("hold_rdata", resp_rdata, held);
        check("hold_req_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      @(negedge clk);
      check("post_hs_valid", 32'(resp_valid), 32'd0);
      check("post_hs_ready", 32'(req_ready), 32'd1);
    end
    check("dm_wr_count", 32'(wr_cnt), (!e_err && we) ? 32'd1 : 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          hold;
  } vec_t;

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{1'b0, 3'b010, 32'h28,   32'h0,         1'b0, 32'h0000_0064, 0};
    tbl[1]  = '{1'b1, 3'b000, 32'h6,    32'h1234_56A5, 1'b0, 32'h0,         0};
    tbl[2]  = '{1'b0, 3'b000, 32'h6,    32'h0,         1'b0, 32'hFFFF_FFA5, 0};
    tbl[3]  = '{1'b0, 3'b100, 32'h6,    32'h0,         1'b0, 32'h0000_00A5, 0};
    tbl[4]  = '{1'b1, 3'b001, 32'h3,    32'hFFFF_FFFF, 1'b1, 32'h0,         0};
    tbl[5]  = '{1'b0, 3'b010, 32'h1000, 32'h0,         1'b1, 32'h0,         0};
    tbl[6]  = '{1'b1, 3'b010, 32'h8,    32'hDEAD_BEEF, 1'b0, 32'h0,         0};
    tbl[7]  = '{1'b0, 3'b001, 32'hA,    32'h0,         1'b0, 32'hFFFF_DEAD, 0};
    tbl[8]  = '{1'b0, 3'b101, 32'h8,    32'h0,         1'b0, 32'h0000_BEEF, 0};
    tbl[9]  = '{1'b0, 3'b010, 32'h4,    32'h0,         1'b0, 32'h00A5_000A, 5};
    tbl[10] = '{1'b0, 3'b011, 32'h0,    32'h0,         1'b1, 32'h0,         0};
    tbl[11] = '{1'b1, 3'b100, 32'h4,    32'h55,        1'b1, 32'h0,         1};
    tbl[12] = '{1'b0, 3'b010, 32'h2,    32'h0,         1'b1, 32'h0,         0};
    tbl[13] = '{1'b0, 3'b001, 32'h2,    32'h0,         1'b0, 32'h0,         0};
    tbl[14] = '{1'b0, 3'b010, 32'hFFC,  32'h0,         1'b0, 32'h0000_27F6, 2};
    tbl[15] = '{1'b0, 3'b000, 32'h4,    32'h0,         1'b0, 32'h0000_000A, 0};

    for (int i = 0; i < int'(NWORDS); i++) begin
      mem[i]     = 32'(i * 10);
      ref_mem[i] = 32'(i * 10);
    end
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_dm_wr", 32'(dm_wr), 32'd0);
    check("rst_dm_be", 32'(dm_be), 32'd0);
    check("rst_dm_wdata", dm_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++)
      do_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].hold,
             1'b1, tbl[i].exp_err, tbl[i].exp_rdata);

    // Reset while a store is in its access cycle: write is suppressed, request dropped.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h10; req_wdata = 32'h1111_1111;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("mid_dm_wr_before", 32'(dm_wr), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_dm_wr", 32'(dm_wr), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b1, 1'b0, 32'h0000_0028);

    // Random traffic against the reference model.
    for (int n = 0; n < 250; n++) begin
      logic [31:0] a;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 5)       a = 32'($urandom_range(0, 63));
      else if (sel < 9)  a = 32'($urandom_range(0, 4095));
      else               a = $urandom;
      do_req(1'($urandom), 3'($urandom), a, $urandom, int'($urandom_range(0, 2)),
             1'b0, 1'b0, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
